// File: rtl/message_router.sv
// message_router: round-robin arbiter feeding a message queue, with a dispatch
// FSM that delivers each queued message to the context or network controller.
//
// Parameters:
//   NCH    number of request channels (2..16)
//   PW     message parameter width per channel
//   DEPTH  message queue depth (power of two, 2..64)
//   TMO    delivery timeout in cycles (1..65535), used only with the watchdog
//   DSTMAP bit i = 1 routes channel i to the network, 0 to the context controller
//
// Ports:
//   CLK     clock, rising edge
//   RESET   synchronous active-high reset
//   REQ     level request per channel
//   PARAM   channel i parameter in bits [i*PW +: PW]
//   ACK     one-cycle grant pulse per channel
//   MSG     {channel index, parameter} of the message being presented
//   CTXVLD  message valid toward context controller
//   CTXRDY  context controller accepts
//   NETVLD  message valid toward network controller
//   NETRDY  network controller accepts
//   LEVEL   queue occupancy (excludes the message held in MSG)
//   ESTB    one-cycle error strobe
//   ERRC    error code: [15:8] code, [7:0] channel index
//
// Optional feature: define MESSAGE_ROUTER_TIMEOUT_EN to build the delivery
// watchdog; without it ESTB and ERRC are tied to zero.

module message_router #(
  parameter int unsigned      NCH    = 4,
  parameter int unsigned      PW     = 64,
  parameter int unsigned      DEPTH  = 4,
  parameter int unsigned      TMO    = 1023,
  parameter logic [NCH-1:0]   DSTMAP = '0,
  localparam int unsigned     CW     = ($clog2(NCH) > 1) ? $clog2(NCH) : 1,
  localparam int unsigned     LW     = $clog2(DEPTH) + 1
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [NCH-1:0]      REQ,
  input  logic [NCH*PW-1:0]   PARAM,
  output logic [NCH-1:0]      ACK,
  output logic [CW+PW-1:0]    MSG,
  output logic                CTXVLD,
  input  logic                CTXRDY,
  output logic                NETVLD,
  input  logic                NETRDY,
  output logic [LW-1:0]       LEVEL,
  output logic                ESTB,
  output logic [15:0]         ERRC
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned MW = CW + PW;
  localparam int unsigned DW = 1 << CW;
  // Destination map widened so any CW-bit channel index selects a valid bit.
  localparam logic [DW-1:0] DST_EXT = DW'(DSTMAP);

  // Elaboration-time parameter range checks
  if (NCH < 2 || NCH > 16) begin : g_chk_nch
    $error("message_router: NCH out of range");
  end
  if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
    $error("message_router: DEPTH must be a power of two in 2..64");
  end
  if (TMO < 1 || TMO > 65535) begin : g_chk_tmo
    $error("message_router: TMO out of range");
  end

  typedef enum logic {IDLE, SEND} state_t;

  // Queue storage and pointers
  logic [MW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;

  // Arbitration state; ack doubles as the one-edge mask of the last grantee
  logic [CW-1:0]  rr_ptr;
  logic [NCH-1:0] ack;

  // Dispatch state
  state_t        state;
  logic [MW-1:0] msg;
  logic          ctx_vld;
  logic          net_vld;

  logic [NCH-1:0] elig_c;
  logic           full_c;
  logic           grant_c;
  logic [CW-1:0]  gnt_idx_c;
  logic [PW-1:0]  gnt_param_c;
  logic           xfer_c;
  logic           tmo_hit_c;
  logic           done_c;
  logic           pop_c;
  logic [MW-1:0]  head_c;
  logic           dst_net_c;
  int unsigned    idx;

  assign elig_c = REQ & ~ack;
  // Full blocks grants even if a pop happens at the same edge.
  assign full_c = (level == LW'(DEPTH));

  // Round-robin search starting at the channel after the last grantee
  always_comb begin
    grant_c   = 1'b0;
    gnt_idx_c = '0;
    idx       = 0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      idx = (32'(rr_ptr) + k) % NCH;
      if (!grant_c && !full_c && elig_c[CW'(idx)]) begin
        grant_c   = 1'b1;
        gnt_idx_c = CW'(idx);
      end
    end
  end

  // Parameter slice of the granted channel
  always_comb begin
    gnt_param_c = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (gnt_idx_c == CW'(i)) begin
        gnt_param_c = PARAM[i*PW +: PW];
      end
    end
  end

  // Only the RDY of the selected destination can complete a transfer.
  assign xfer_c    = (ctx_vld && CTXRDY) || (net_vld && NETRDY);
  assign done_c    = xfer_c || tmo_hit_c;
  assign pop_c     = (level != '0) &&
                     ((state == IDLE) || ((state == SEND) && done_c));
  assign head_c    = mem[rd_ptr];
  assign dst_net_c = DST_EXT[head_c[MW-1 -: CW]];

  // Queue, grant pulse and round-robin pointer
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      rr_ptr <= CW'(NCH - 1);
      ack    <= '0;
    end else begin
      ack <= '0;
      if (grant_c) begin
        mem[wr_ptr]    <= {gnt_idx_c, gnt_param_c};
        wr_ptr         <= wr_ptr + AW'(1);
        rr_ptr         <= gnt_idx_c;
        ack[gnt_idx_c] <= 1'b1;
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      level <= level + LW'(grant_c) - LW'(pop_c);
    end
  end

  // Dispatch FSM: IDLE loads the head, SEND presents it until done
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      msg     <= '0;
      ctx_vld <= 1'b0;
      net_vld <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop_c) begin
            msg     <= head_c;
            ctx_vld <= !dst_net_c;
            net_vld <= dst_net_c;
            state   <= SEND;
          end
        end
        SEND: begin
          if (done_c) begin
            if (pop_c) begin
              msg     <= head_c;
              ctx_vld <= !dst_net_c;
              net_vld <= dst_net_c;
            end else begin
              ctx_vld <= 1'b0;
              net_vld <= 1'b0;
              state   <= IDLE;
            end
          end
        end
        default: begin
          state   <= IDLE;
          ctx_vld <= 1'b0;
          net_vld <= 1'b0;
        end
      endcase
    end
  end

`ifdef MESSAGE_ROUTER_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        estb;
  logic [15:0] errc;

  // Counter reaching TMO at this edge means the message has waited TMO cycles.
  assign tmo_hit_c = (state == SEND) && !xfer_c && (tmo_cnt == 16'(TMO - 1));

  // Delivery watchdog
  always_ff @(posedge CLK) begin
    if (RESET) begin
      tmo_cnt <= '0;
      estb    <= 1'b0;
      errc    <= '0;
    end else begin
      estb <= 1'b0;
      if (state != SEND || done_c) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 16'd1;
      end
      if (tmo_hit_c) begin
        estb <= 1'b1;
        errc <= {8'h01, 8'(msg[MW-1 -: CW])};
      end
    end
  end

  assign ESTB = estb;
  assign ERRC = errc;
`else
  assign tmo_hit_c = 1'b0;
  assign ESTB      = 1'b0;
  assign ERRC      = '0;
`endif

  assign ACK    = ack;
  assign MSG    = msg;
  assign CTXVLD = ctx_vld;
  assign NETVLD = net_vld;
  assign LEVEL  = level;

endmodule

// File: tb/tb_message_router.sv
// tb_message_router: directed bench for message_router with a scoreboard of
// expected messages (pushed on grant, popped on delivery).

module tb_message_router;

  localparam int unsigned NCH   = 4;
  localparam int unsigned PW    = 64;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 8;
  localparam int unsigned CW    = 2;
  localparam int unsigned MW    = CW + PW;
  localparam int unsigned LW    = 3;
  localparam logic [NCH-1:0] DSTMAP = 4'b0010;
`ifdef MESSAGE_ROUTER_TIMEOUT_EN
  localparam int HOLD = 3;
`else
  localparam int HOLD = 20;
`endif

  logic              CLK = 1'b0;
  logic              RESET;
  logic [NCH-1:0]    REQ;
  logic [NCH*PW-1:0] PARAM;
  logic [NCH-1:0]    ACK;
  logic [MW-1:0]     MSG;
  logic              CTXVLD;
  logic              CTXRDY;
  logic              NETVLD;
  logic              NETRDY;
  logic [LW-1:0]     LEVEL;
  logic              ESTB;
  logic [15:0]       ERRC;

  logic [PW-1:0] prm [NCH];
  assign PARAM = {prm[3], prm[2], prm[1], prm[0]};

  message_router #(
    .NCH(NCH), .PW(PW), .DEPTH(DEPTH), .TMO(TMO), .DSTMAP(DSTMAP)
  ) dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .PARAM(PARAM), .ACK(ACK), .MSG(MSG),
    .CTXVLD(CTXVLD), .CTXRDY(CTXRDY), .NETVLD(NETVLD), .NETRDY(NETRDY),
    .LEVEL(LEVEL), .ESTB(ESTB), .ERRC(ERRC)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [MW-1:0] sb [$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [MW-1:0] mk(input logic [CW-1:0] ch, input logic [PW-1:0] p);
    return {ch, p};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Raise one request, wait for its grant, record the expected message, drop it.
  task automatic req_one(input logic [CW-1:0] ch, input string tag);
    int t;
    logic [NCH-1:0] e;
    t = 0;
    e = '0;
    e[ch] = 1'b1;
    REQ[ch] = 1'b1;
    step();
    while (ACK[ch] !== 1'b1 && t < 20) begin
      step();
      t++;
    end
    chk(tag, 128'(ACK), 128'(e));
    if (ACK[ch] === 1'b1) sb.push_back(mk(ch, prm[ch]));
    REQ[ch] = 1'b0;
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 40) begin
      step();
      t++;
    end
    chk(tag, 128'(sb.size()), 128'(0));
    step();
  endtask

  // Delivery monitor: compare every completed transfer with the scoreboard head.
  always @(negedge CLK) begin
    logic [MW-1:0] exp;
    if (!RESET && ((CTXVLD && CTXRDY) || (NETVLD && NETRDY))) begin
      chk("sb_has_entry", 128'(sb.size() != 0), 128'(1));
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        chk("deliver_msg", 128'(MSG), 128'(exp));
        chk("deliver_dest", 128'({CTXVLD, NETVLD}),
            128'(DSTMAP[exp[MW-1 -: CW]] ? 2'b01 : 2'b10));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int t;
    logic [NCH-1:0] e;

    // Reset with requests pending: nothing may be granted.
    RESET  = 1'b1;
    REQ    = 4'b1111;
    CTXRDY = 1'b0;
    NETRDY = 1'b0;
    for (int i = 0; i < NCH; i++) prm[i] = '0;
    step(); step(); step();
    chk("rst_ack", 128'(ACK), 128'(0));
    chk("rst_ctxvld", 128'(CTXVLD), 128'(0));
    chk("rst_netvld", 128'(NETVLD), 128'(0));
    chk("rst_level", 128'(LEVEL), 128'(0));
    chk("rst_msg", 128'(MSG), 128'(0));
    chk("rst_estb", 128'(ESTB), 128'(0));
    chk("rst_errc", 128'(ERRC), 128'(0));
    RESET = 1'b0;
    REQ   = '0;

    // Round-robin order with all channels requesting, dropped on ACK.
    for (int k = 0; k < NCH; k++) begin
      prm[k] = 64'h1000 + 64'(k);
      sb.push_back(mk(CW'(k), prm[k]));
    end
    CTXRDY = 1'b1;
    NETRDY = 1'b1;
    REQ    = 4'b1111;
    for (int k = 0; k < NCH; k++) begin
      step();
      e = NCH'(1) << k;
      chk($sformatf("rr_ack%0d", k), 128'(ACK), 128'(e));
      REQ = REQ & ~ACK;
    end
    REQ = '0;
    drain("rr_drain");
    chk("rr_level_empty", 128'(LEVEL), 128'(0));

    // Back-pressure: one message parked in MSG, then fill the queue from ch0.
    CTXRDY = 1'b0;
    NETRDY = 1'b0;
    prm[2] = 64'hC2;
    req_one(2'd2, "blk_ack2");
    t = 0;
    while (CTXVLD !== 1'b1 && t < 10) begin
      step();
      t++;
    end
    chk("blk_vld", 128'(CTXVLD), 128'(1));
    n = 0;
    prm[0] = 64'hB000;
    REQ[0] = 1'b1;
    repeat (30) begin
      step();
      if (ACK[0] === 1'b1) begin
        sb.push_back(mk(2'd0, prm[0]));
        n++;
        prm[0] = 64'hB000 + 64'(n);
      end
    end
    chk("full_acks", 128'(n), 128'(4));
    chk("full_level", 128'(LEVEL), 128'(4));
    chk("full_no_ack", 128'(ACK), 128'(0));
    chk("full_head", 128'(MSG), 128'({2'd2, 64'hC2}));
    CTXRDY = 1'b1;
    t = 0;
    while (n < 6 && t < 40) begin
      step();
      if (ACK[0] === 1'b1) begin
        sb.push_back(mk(2'd0, prm[0]));
        n++;
        prm[0] = 64'hB000 + 64'(n);
        if (n == 6) REQ[0] = 1'b0;
      end
      t++;
    end
    REQ[0] = 1'b0;
    chk("full_total_acks", 128'(n), 128'(6));
    drain("full_drain");

    // Network-routed channel; CTXRDY high must not complete it.
    CTXRDY = 1'b1;
    NETRDY = 1'b0;
    prm[1] = 64'hA5;
    req_one(2'd1, "net_ack1");
    t = 0;
    while (NETVLD !== 1'b1 && t < 10) begin
      step();
      t++;
    end
    chk("net_vld", 128'(NETVLD), 128'(1));
    chk("net_ctxvld", 128'(CTXVLD), 128'(0));
    chk("net_msg", 128'(MSG), 128'({2'd1, 64'hA5}));
    repeat (HOLD) step();
    chk("net_hold_vld", 128'(NETVLD), 128'(1));
    chk("net_hold_msg", 128'(MSG), 128'({2'd1, 64'hA5}));
    chk("net_hold_estb", 128'(ESTB), 128'(0));
    NETRDY = 1'b1;
    drain("net_drain");

`ifdef MESSAGE_ROUTER_TIMEOUT_EN
    // Watchdog: ch3 message times out, ch0 message is presented next.
    CTXRDY = 1'b0;
    NETRDY = 1'b0;
    prm[3] = 64'hD3;
    prm[0] = 64'hD0;
    REQ = 4'b1001;
    step();
    chk("tmo_ack3", 128'(ACK), 128'(4'b1000));
    sb.push_back(mk(2'd3, prm[3]));
    REQ = 4'b0001;
    step();
    chk("tmo_ack0", 128'(ACK), 128'(4'b0001));
    sb.push_back(mk(2'd0, prm[0]));
    REQ = '0;
    chk("tmo_vld_rise", 128'(CTXVLD), 128'(1));
    t = 0;
    while (ESTB !== 1'b1 && t < 20) begin
      step();
      t++;
    end
    chk("tmo_delay", 128'(t), 128'(TMO));
    chk("tmo_errc", 128'(ERRC), 128'(16'h0103));
    chk("tmo_next_msg", 128'(MSG), 128'({2'd0, 64'hD0}));
    chk("tmo_next_vld", 128'(CTXVLD), 128'(1));
    if (sb.size() != 0) void'(sb.pop_front());
    step();
    chk("tmo_estb_pulse", 128'(ESTB), 128'(0));
    CTXRDY = 1'b1;
    drain("tmo_drain");
`endif

    // Reset in SEND with three queued messages.
    CTXRDY = 1'b0;
    NETRDY = 1'b0;
    prm[0] = 64'hE0;
    REQ[0] = 1'b1;
    n = 0;
    t = 0;
    while (n < 4 && t < 30) begin
      step();
      if (ACK[0] === 1'b1) begin
        n++;
        if (n == 4) REQ[0] = 1'b0;
      end
      t++;
    end
    REQ[0] = 1'b0;
    chk("mid_level3", 128'(LEVEL), 128'(3));
    chk("mid_vld", 128'(CTXVLD), 128'(1));
    RESET = 1'b1;
    REQ   = 4'b1111;
    step();
    chk("mid_rst_vld", 128'({CTXVLD, NETVLD}), 128'(0));
    chk("mid_rst_level", 128'(LEVEL), 128'(0));
    chk("mid_rst_ack", 128'(ACK), 128'(0));
    sb.delete();
    RESET = 1'b0;
    step();
    chk("mid_first_grant", 128'(ACK), 128'(4'b0001));
    REQ = '0;
    if (ACK[0] === 1'b1) sb.push_back(mk(2'd0, prm[0]));
    CTXRDY = 1'b1;
    drain("mid_drain");
    chk("final_level", 128'(LEVEL), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
